hps_lw_axi_apb_bridge: RTL
==========================

HPS_LW_AXI_APB_BRIDGE -- requirements
Module: hps_lw_axi_apb_bridge

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk, input, 1: sole clock; all flops rise on it.
- reset_n, input, 1: asynchronous active-low reset.
- ar__valid/id/addr/len/size/burst, input, 1/12/32/4/3/2: AXI3 read address; lock/cache/prot/qos/region/user are accepted and ignored.
- arready, output, 1: read address accept.
- aw__valid/id/addr/len/size/burst, input, 1/12/32/4/3/2: AXI3 write address; other fields are ignored.
- awready, output, 1: write address accept.
- w__valid/id/data/strb/last, input, 1/12/32/4/1: write data; w__id and w__user are ignored.
- wready, output, 1: write data accept.
- r__valid/id/data/resp/last/user, output, 1/12/32/2/1/4: read data; r__user is always 0.
- rready, input, 1: read data accept.
- b__valid/id/resp/user, output, 1/12/2/4: write response; b__user is always 0.
- bready, input, 1: write response accept.
- psel, penable, pwrite, output, 1 each: APB control.
- paddr, output, 16: APB byte address, taken from addr[15:0].
- pwdata, output, 32: APB write data.
- pstrb, output, 4: APB write strobes.
- prdata, input, 32: APB read data.
- pready, input, 1: APB ready.
- pslverr, input, 1: APB error.

Function
REQ-003 The block SHALL have at most one AXI transaction in flight; it SHALL NOT accept a new address until the previous response has completed.
REQ-004 The FSM states SHALL be IDLE, RD_SETUP, RD_ACCESS, RD_RESP, WR_DATA, WR_SETUP, WR_ACCESS and WR_RESP.
REQ-005 In IDLE, arready and awready SHALL be driven combinationally from the state and the priority flag; at most one of them is high in any cycle.
REQ-006 Arbitration SHALL work as follows:
- If only one of ar__valid/aw__valid is high, that channel is granted.
- If both are high, the channel named by the priority flag is granted, and the flag then toggles.
- The priority flag resets to read.
REQ-007 On an address handshake, the block SHALL latch id, addr, len and burst, and SHALL clear the beat counter.
- A read then goes to RD_SETUP.
- A write then goes to WR_DATA.
REQ-008 In WR_DATA, wready SHALL be 1; on w__valid the block SHALL latch data and strb and go to WR_SETUP.
- Beat count is set by len, not by w__last.
- A w__last mismatch SHALL be ignored.
REQ-009 In *_SETUP, psel SHALL be 1 and penable 0, for exactly one cycle. In *_ACCESS, psel and penable SHALL both be 1 until pready; paddr/pwrite/pwdata/pstrb SHALL be stable across SETUP and ACCESS.
REQ-010 pstrb SHALL be 0 for reads and pwdata SHALL be 0 for reads.
REQ-011 On pready in RD_ACCESS, the block SHALL go to RD_RESP and register prdata and pslverr.
- r__valid is 1 in RD_RESP, and r__data, r__resp and r__last are held until rready.
- r__resp is 2'b10 if pslverr was set, else 2'b00.
- r__last is 1 on beat len.
- r__id is the latched id.
REQ-012 On the rready handshake, the block SHALL go to RD_SETUP with the next address if beats remain, else to IDLE.
REQ-013 On pready in WR_ACCESS, the block SHALL OR pslverr into a sticky error bit; it then goes to WR_DATA if beats remain, else to WR_RESP.
REQ-014 In WR_RESP, b__valid SHALL be 1 and b__id is the latched id.
- b__resp is 2'b10 if the sticky error is set, else 2'b00.
- On bready the block SHALL clear the sticky bit and go to IDLE.
REQ-015 Address stepping SHALL follow the burst type:
- INCR (01) and WRAP (10): addr += 4 per beat, 32-bit unsigned, wrapping mod 2^32.
- FIXED (00): the address does not change.
- WRAP is deliberately treated as INCR.
- The size field is ignored: every beat is 32 bits.
REQ-016 The beat counter SHALL be 4 bits; len=15 gives exactly 16 beats with no overflow.
REQ-017 APB latency SHALL be 2 cycles per beat when pready is already high in ACCESS; there SHALL be no timeout.
REQ-018 r__valid and b__valid SHALL never be high at the same time.

Reset
REQ-019 While reset_n is low, or asynchronously on its assertion, the block SHALL force:
- state = IDLE and priority = read;
- sticky error = 0 and beat counter = 0;
- psel, penable, pwrite = 0;
- r__valid, b__valid, arready, awready, wready = 0 (the readies stay 0 while reset_n is low);
- all data, id and resp outputs = 0.
REQ-020 Reset asserted mid-transaction (including during APB ACCESS) SHALL abandon the transaction with no response.
REQ-021 After reset release, IDLE readies SHALL be valid on the first clock edge.

Verification
REQ-022 Single read: ar id=0x5A, addr=0x0000_1004, len=0; pready=1, prdata=0xDEADBEEF
- -> SETUP at paddr=0x1004, then ACCESS;
- -> r__data=0xDEADBEEF, r__resp=0, r__last=1, r__id=0x5A;
- -> state returns to IDLE.
REQ-023 INCR write: len=3, addr=0x100, strb=0xF per beat
- -> paddr sequence 0x100, 0x104, 0x108, 0x10C;
- -> one b response, b__resp=0;
- -> w__last=0 on every beat does not change the behaviour.
REQ-024 FIXED read, len=15, with pslverr=1 on beat 7 only
- -> 16 APB reads, all at the same paddr;
- -> r__resp=2 on beat 7 only;
- -> r__last=1 on beat 15.
REQ-025 ar and aw valid in the same cycle after reset
- -> the read is granted first;
- -> the next simultaneous request grants the write;
- -> the flag alternates while both stay pending.
REQ-026 Backpressure: rready=0 for 5 cycles, and pready delayed 3 cycles
- -> r__valid and r__data stay stable;
- -> no new psel until after the rready handshake.
REQ-027 reset_n pulled low during WR_ACCESS of a 4-beat write
- -> psel, penable and b__valid go to 0 asynchronously;
- -> no b response appears;
- -> a new ar after release completes normally.

Source files
------------

// File: rtl/hps_lw_axi_apb_bridge.sv
// Lightweight AXI3-to-APB bridge: one AXI transaction in flight, one APB
// access per beat, read/write arbitration with a toggling priority flag.
module hps_lw_axi_apb_bridge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ar__valid,
  input  logic [11:0] ar__id,
  input  logic [31:0] ar__addr,
  input  logic [3:0]  ar__len,
  input  logic [2:0]  ar__size,
  input  logic [1:0]  ar__burst,
  output logic        arready,
  input  logic        aw__valid,
  input  logic [11:0] aw__id,
  input  logic [31:0] aw__addr,
  input  logic [3:0]  aw__len,
  input  logic [2:0]  aw__size,
  input  logic [1:0]  aw__burst,
  output logic        awready,
  input  logic        w__valid,
  input  logic [11:0] w__id,
  input  logic [31:0] w__data,
  input  logic [3:0]  w__strb,
  input  logic        w__last,
  output logic        wready,
  output logic        r__valid,
  output logic [11:0] r__id,
  output logic [31:0] r__data,
  output logic [1:0]  r__resp,
  output logic        r__last,
  output logic [3:0]  r__user,
  input  logic        rready,
  output logic        b__valid,
  output logic [11:0] b__id,
  output logic [1:0]  b__resp,
  output logic [3:0]  b__user,
  input  logic        bready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_ACCESS, RD_RESP, WR_DATA, WR_SETUP, WR_ACCESS, WR_RESP
  } state_t;

  state_t      state;
  logic        prio_wr;   // 0: read wins a tie, 1: write wins
  logic [11:0] id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic [1:0]  burst_q;
  logic        err_q;     // sticky write error across beats

  logic        idle;
  logic        last_beat;
  logic [31:0] addr_nxt;
  logic        unused;

  // Size is ignored (every beat is 32 bits); w id/last carry no meaning here.
  assign unused = ^{ar__size, aw__size, w__id, w__last};

  assign r__user = 4'd0;
  assign b__user = 4'd0;

  // Readies come straight from state, priority and the valids so a grant can
  // happen on the first edge after reset release.
  assign idle    = reset_n && (state == IDLE);
  assign arready = idle && ar__valid && (!aw__valid || !prio_wr);
  assign awready = idle && aw__valid && (!ar__valid || prio_wr);

  // WRAP is stepped like INCR; FIXED keeps the address.
  assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + 32'd4;
  assign last_beat = (beat_q == len_q);

  // Transaction FSM; all AXI response and APB outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prio_wr  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      wready   <= 1'b0;
      r__valid <= 1'b0;
      r__id    <= '0;
      r__data  <= '0;
      r__resp  <= '0;
      r__last  <= 1'b0;
      b__valid <= 1'b0;
      b__id    <= '0;
      b__resp  <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar__valid && aw__valid) prio_wr <= ~prio_wr;
          if (arready) begin
            id_q    <= ar__id;
            addr_q  <= ar__addr;
            len_q   <= ar__len;
            burst_q <= ar__burst;
            beat_q  <= '0;
            psel    <= 1'b1;
            pwrite  <= 1'b0;
            paddr   <= ar__addr[15:0];
            pwdata  <= '0;
            pstrb   <= '0;
            state   <= RD_SETUP;
          end else if (awready) begin
            id_q    <= aw__id;
            addr_q  <= aw__addr;
            len_q   <= aw__len;
            burst_q <= aw__burst;
            beat_q  <= '0;
            wready  <= 1'b1;
            state   <= WR_DATA;
          end
        end
        RD_SETUP: begin
          penable <= 1'b1;
          state   <= RD_ACCESS;
        end
        RD_ACCESS: if (pready) begin
          psel     <= 1'b0;
          penable  <= 1'b0;
          r__valid <= 1'b1;
          r__id    <= id_q;
          r__data  <= prdata;
          r__resp  <= pslverr ? 2'b10 : 2'b00;
          r__last  <= last_beat;
          state    <= RD_RESP;
        end
        RD_RESP: if (rready) begin
          r__valid <= 1'b0;
          if (last_beat) begin
            state <= IDLE;
          end else begin
            beat_q <= beat_q + 4'd1;
            addr_q <= addr_nxt;
            paddr  <= addr_nxt[15:0];
            psel   <= 1'b1;
            state  <= RD_SETUP;
          end
        end
        WR_DATA: if (w__valid) begin
          wready <= 1'b0;
          pwdata <= w__data;
          pstrb  <= w__strb;
          pwrite <= 1'b1;
          paddr  <= addr_q[15:0];
          psel   <= 1'b1;
          state  <= WR_SETUP;
        end
        WR_SETUP: begin
          penable <= 1'b1;
          state   <= WR_ACCESS;
        end
        WR_ACCESS: if (pready) begin
          psel    <= 1'b0;
          penable <= 1'b0;
          err_q   <= err_q | pslverr;
          if (last_beat) begin
            b__valid <= 1'b1;
            b__id    <= id_q;
            b__resp  <= (err_q | pslverr) ? 2'b10 : 2'b00;
            state    <= WR_RESP;
          end else begin
            beat_q <= beat_q + 4'd1;
            addr_q <= addr_nxt;
            wready <= 1'b1;
            state  <= WR_DATA;
          end
        end
        WR_RESP: if (bready) begin
          b__valid <= 1'b0;
          err_q    <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
